// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcode constants and payload types for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int unsigned OP_WID      = 7;
  localparam int unsigned FUNCT3_WID  = 3;
  localparam int unsigned FUNCT7_WID  = 1;
  localparam int unsigned ROB_POS_WID = 4;
  localparam int unsigned DATA_WID    = 32;
  localparam int unsigned RS_SIZE_DEF = 16;

  localparam logic [OP_WID-1:0] OP_ARITH  = 7'b0110011;
  localparam logic [OP_WID-1:0] OP_ARITHI = 7'b0010011;
  localparam logic [OP_WID-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_WID-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_WID-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_WID-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_WID-1:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [OP_WID-1:0]     opcode;
    logic [FUNCT3_WID-1:0] funct3;
    logic [FUNCT7_WID-1:0] funct7;
  } op_fields_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the reservation station.
interface alu_reservation_station_if
  import alu_reservation_station_pkg::*;
#(
  parameter int unsigned ROB_POS_W = ROB_POS_WID
);
  logic                  disp_valid;
  logic [OP_WID-1:0]     disp_opcode;
  logic [FUNCT3_WID-1:0] disp_funct3;
  logic [FUNCT7_WID-1:0] disp_funct7;
  logic [DATA_WID-1:0]   disp_imm;
  logic [DATA_WID-1:0]   disp_pc;
  logic [ROB_POS_W-1:0]  disp_rob_pos;
  logic                  disp_rs1_ready;
  logic [DATA_WID-1:0]   disp_rs1_val;
  logic [ROB_POS_W-1:0]  disp_rs1_tag;
  logic                  disp_rs2_ready;
  logic [DATA_WID-1:0]   disp_rs2_val;
  logic [ROB_POS_W-1:0]  disp_rs2_tag;
  logic                  rs_full;

  logic                  alu_result;
  logic [ROB_POS_W-1:0]  alu_result_rob_pos;
  logic [DATA_WID-1:0]   alu_result_val;
  logic                  lsb_result;
  logic [ROB_POS_W-1:0]  lsb_result_rob_pos;
  logic [DATA_WID-1:0]   lsb_result_val;

  logic                  alu_en;
  logic [OP_WID-1:0]     alu_opcode;
  logic [FUNCT3_WID-1:0] alu_funct3;
  logic [FUNCT7_WID-1:0] alu_funct7;
  logic [DATA_WID-1:0]   alu_val1;
  logic [DATA_WID-1:0]   alu_val2;
  logic [DATA_WID-1:0]   alu_imm;
  logic [DATA_WID-1:0]   alu_pc;
  logic [ROB_POS_W-1:0]  alu_rob_pos;

  modport master (
    output disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc, disp_rob_pos,
    output disp_rs1_ready, disp_rs1_val, disp_rs1_tag, disp_rs2_ready, disp_rs2_val, disp_rs2_tag,
    output alu_result, alu_result_rob_pos, alu_result_val,
    output lsb_result, lsb_result_rob_pos, lsb_result_val,
    input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
    input  alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc, disp_rob_pos,
    input  disp_rs1_ready, disp_rs1_val, disp_rs1_tag, disp_rs2_ready, disp_rs2_val, disp_rs2_tag,
    input  alu_result, alu_result_rob_pos, alu_result_val,
    input  lsb_result, lsb_result_rob_pos, lsb_result_val,
    output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
    output alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );

endinterface

// File: rtl/alu_reservation_station_rs_pick.sv
// rs_pick: lowest-index priority encoder returning a found flag and the winning index.
module alu_reservation_station_rs_pick #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found_c,
  output logic [W-1:0] idx_c
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: buffers dispatched ops, wakes operands from
// ALU/LSB broadcasts, issues one ready entry per cycle. Option: RS_CDB_BYPASS_EN.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE   = RS_SIZE_DEF,
  parameter int unsigned ROB_POS_W = ROB_POS_WID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  alu_reservation_station_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  typedef logic [ROB_POS_W-1:0] tag_t;
  typedef logic [DATA_WID-1:0]  data_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] r1_q, r1_d, r2_q, r2_d;
  op_fields_t         op_q   [RS_SIZE];
  op_fields_t         op_d   [RS_SIZE];
  data_t              imm_q  [RS_SIZE];
  data_t              imm_d  [RS_SIZE];
  data_t              pc_q   [RS_SIZE];
  data_t              pc_d   [RS_SIZE];
  tag_t               rob_q  [RS_SIZE];
  tag_t               rob_d  [RS_SIZE];
  data_t              v1_q   [RS_SIZE];
  data_t              v1_d   [RS_SIZE];
  data_t              v2_q   [RS_SIZE];
  data_t              v2_d   [RS_SIZE];
  tag_t               t1_q   [RS_SIZE];
  tag_t               t1_d   [RS_SIZE];
  tag_t               t2_q   [RS_SIZE];
  tag_t               t2_d   [RS_SIZE];

  logic       alu_en_q, alu_en_d;
  op_fields_t alu_op_q, alu_op_d;
  data_t      alu_val1_q, alu_val1_d;
  data_t      alu_val2_q, alu_val2_d;
  data_t      alu_imm_q, alu_imm_d;
  data_t      alu_pc_q, alu_pc_d;
  tag_t       alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0] hit1_c, hit2_c, ready_vec_c;
  data_t              bv1_c [RS_SIZE];
  data_t              bv2_c [RS_SIZE];
  logic               d_alu1_c, d_lsb1_c, d_alu2_c, d_lsb2_c;
  logic               free_found_c, iss_found_c;
  logic [IDX_W-1:0]   free_idx_c, iss_idx_c;

  // Broadcast match per stored operand; the ALU bus wins when both buses carry the tag.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      hit1_c[i] = !r1_q[i] &&
                  ((bus.alu_result && (bus.alu_result_rob_pos == t1_q[i])) ||
                   (bus.lsb_result && (bus.lsb_result_rob_pos == t1_q[i])));
      hit2_c[i] = !r2_q[i] &&
                  ((bus.alu_result && (bus.alu_result_rob_pos == t2_q[i])) ||
                   (bus.lsb_result && (bus.lsb_result_rob_pos == t2_q[i])));
      bv1_c[i]  = (bus.alu_result && (bus.alu_result_rob_pos == t1_q[i])) ?
                  bus.alu_result_val : bus.lsb_result_val;
      bv2_c[i]  = (bus.alu_result && (bus.alu_result_rob_pos == t2_q[i])) ?
                  bus.alu_result_val : bus.lsb_result_val;
`ifdef RS_CDB_BYPASS_EN
      ready_vec_c[i] = busy_q[i] && (r1_q[i] || hit1_c[i]) && (r2_q[i] || hit2_c[i]);
`else
      ready_vec_c[i] = busy_q[i] && r1_q[i] && r2_q[i];
`endif
    end
    d_alu1_c = bus.alu_result && (bus.alu_result_rob_pos == bus.disp_rs1_tag);
    d_lsb1_c = bus.lsb_result && (bus.lsb_result_rob_pos == bus.disp_rs1_tag);
    d_alu2_c = bus.alu_result && (bus.alu_result_rob_pos == bus.disp_rs2_tag);
    d_lsb2_c = bus.lsb_result && (bus.lsb_result_rob_pos == bus.disp_rs2_tag);
  end

  alu_reservation_station_rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_free (
    .req     (~busy_q),
    .found_c (free_found_c),
    .idx_c   (free_idx_c)
  );

  alu_reservation_station_rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_ready (
    .req     (ready_vec_c),
    .found_c (iss_found_c),
    .idx_c   (iss_idx_c)
  );

  // Next state: rollback flush, else wakeup + issue + dispatch (issue frees a slot only next cycle).
  always_comb begin
    busy_d     = busy_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    op_d       = op_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rob_d      = rob_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    alu_en_d   = 1'b0;
    alu_op_d   = alu_op_q;
    alu_val1_d = alu_val1_q;
    alu_val2_d = alu_val2_q;
    alu_imm_d  = alu_imm_q;
    alu_pc_d   = alu_pc_q;
    alu_rob_d  = alu_rob_q;

    if (rollback) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (busy_q[i] && hit1_c[i]) begin
          r1_d[i] = 1'b1;
          v1_d[i] = bv1_c[i];
        end
        if (busy_q[i] && hit2_c[i]) begin
          r2_d[i] = 1'b1;
          v2_d[i] = bv2_c[i];
        end
      end

      if (iss_found_c) begin
        busy_d[iss_idx_c] = 1'b0;
        alu_en_d          = 1'b1;
        alu_op_d          = op_q[iss_idx_c];
        alu_val1_d        = r1_q[iss_idx_c] ? v1_q[iss_idx_c] : bv1_c[iss_idx_c];
        alu_val2_d        = r2_q[iss_idx_c] ? v2_q[iss_idx_c] : bv2_c[iss_idx_c];
        alu_imm_d         = imm_q[iss_idx_c];
        alu_pc_d          = pc_q[iss_idx_c];
        alu_rob_d         = rob_q[iss_idx_c];
      end

      if (bus.disp_valid && free_found_c) begin
        busy_d[free_idx_c] = 1'b1;
        op_d[free_idx_c]   = '{opcode: bus.disp_opcode, funct3: bus.disp_funct3,
                               funct7: bus.disp_funct7};
        imm_d[free_idx_c]  = bus.disp_imm;
        pc_d[free_idx_c]   = bus.disp_pc;
        rob_d[free_idx_c]  = bus.disp_rob_pos;
        t1_d[free_idx_c]   = bus.disp_rs1_tag;
        t2_d[free_idx_c]   = bus.disp_rs2_tag;
        r1_d[free_idx_c]   = bus.disp_rs1_ready || d_alu1_c || d_lsb1_c;
        r2_d[free_idx_c]   = bus.disp_rs2_ready || d_alu2_c || d_lsb2_c;
        v1_d[free_idx_c]   = bus.disp_rs1_ready ? bus.disp_rs1_val :
                             d_alu1_c ? bus.alu_result_val :
                             d_lsb1_c ? bus.lsb_result_val : bus.disp_rs1_val;
        v2_d[free_idx_c]   = bus.disp_rs2_ready ? bus.disp_rs2_val :
                             d_alu2_c ? bus.alu_result_val :
                             d_lsb2_c ? bus.lsb_result_val : bus.disp_rs2_val;
      end
    end
  end

  // Control and issue registers; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      alu_val1_q <= '0;
      alu_val2_q <= '0;
      alu_imm_q  <= '0;
      alu_pc_q   <= '0;
      alu_rob_q  <= '0;
    end else if (rdy) begin
      busy_q     <= busy_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      alu_val1_q <= alu_val1_d;
      alu_val2_q <= alu_val2_d;
      alu_imm_q  <= alu_imm_d;
      alu_pc_q   <= alu_pc_d;
      alu_rob_q  <= alu_rob_d;
    end
  end

  // Entry storage is qualified by busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      op_q  <= op_d;
      imm_q <= imm_d;
      pc_q  <= pc_d;
      rob_q <= rob_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      t1_q  <= t1_d;
      t2_q  <= t2_d;
    end
  end

  assign bus.rs_full     = &busy_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_opcode  = alu_op_q.opcode;
  assign bus.alu_funct3  = alu_op_q.funct3;
  assign bus.alu_funct7  = alu_op_q.funct7;
  assign bus.alu_val1    = alu_val1_q;
  assign bus.alu_val2    = alu_val2_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.alu_pc      = alu_pc_q;
  assign bus.alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: table vectors, directed corner sequences and
// randomized traffic checked against a slot-array reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int N  = 16;
  localparam int RW = 4;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, rollback;

  alu_reservation_station_if #(.ROB_POS_W(RW)) bus ();

  alu_reservation_station #(.RS_SIZE(N), .ROB_POS_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    bit          r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } ent_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [3:0]  rob;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ab;
    logic [3:0]  ap;
    logic [31:0] av;
    logic        lb;
    logic [3:0]  lp;
    logic [31:0] lv;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  ent_t        m [N];
  logic        e_en;
  logic [6:0]  e_op;
  logic [2:0]  e_f3;
  logic        e_f7;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic bit bhit(logic [3:0] t);
    return (bus.alu_result && bus.alu_result_rob_pos == t) ||
           (bus.lsb_result && bus.lsb_result_rob_pos == t);
  endfunction

  function automatic logic [31:0] bval(logic [3:0] t);
    if (bus.alu_result && bus.alu_result_rob_pos == t) return bus.alu_result_val;
    return bus.lsb_result_val;
  endfunction

  // Reference: one clock of the station computed from the current inputs.
  task automatic model_step();
    ent_t nx [N];
    int   sel;
    int   fr;
    if (rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_en = 1'b0; e_op = '0; e_f3 = '0; e_f7 = 1'b0;
      e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
      return;
    end
    if (!rdy) return;
    if (rollback) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_en = 1'b0;
      return;
    end
    nx  = m;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && (m[i].r1 || (BYP && bhit(m[i].t1))) &&
          (m[i].r2 || (BYP && bhit(m[i].t2)))) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    e_en = (sel >= 0);
    if (sel >= 0) begin
      e_op = m[sel].op; e_f3 = m[sel].f3; e_f7 = m[sel].f7;
      e_v1 = m[sel].r1 ? m[sel].v1 : bval(m[sel].t1);
      e_v2 = m[sel].r2 ? m[sel].v2 : bval(m[sel].t2);
      e_imm = m[sel].imm; e_pc = m[sel].pc; e_rob = m[sel].rob;
      nx[sel].busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && !m[i].r1 && bhit(m[i].t1)) begin nx[i].r1 = 1'b1; nx[i].v1 = bval(m[i].t1); end
      if (m[i].busy && !m[i].r2 && bhit(m[i].t2)) begin nx[i].r2 = 1'b1; nx[i].v2 = bval(m[i].t2); end
    end
    if (bus.disp_valid && fr >= 0) begin
      nx[fr].busy = 1'b1;
      nx[fr].op = bus.disp_opcode; nx[fr].f3 = bus.disp_funct3; nx[fr].f7 = bus.disp_funct7;
      nx[fr].imm = bus.disp_imm; nx[fr].pc = bus.disp_pc; nx[fr].rob = bus.disp_rob_pos;
      nx[fr].t1 = bus.disp_rs1_tag; nx[fr].t2 = bus.disp_rs2_tag;
      nx[fr].r1 = bus.disp_rs1_ready || bhit(bus.disp_rs1_tag);
      nx[fr].r2 = bus.disp_rs2_ready || bhit(bus.disp_rs2_tag);
      nx[fr].v1 = bus.disp_rs1_ready ? bus.disp_rs1_val : bval(bus.disp_rs1_tag);
      nx[fr].v2 = bus.disp_rs2_ready ? bus.disp_rs2_val : bval(bus.disp_rs2_tag);
    end
    m = nx;
  endtask

  task automatic check(string nm);
    logic [142:0] got, exp;
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m[i].busy);
    got = {bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, bus.alu_val1, bus.alu_val2,
           bus.alu_imm, bus.alu_pc, bus.alu_rob_pos};
    exp = {e_op, e_f3, e_f7, e_v1, e_v2, e_imm, e_pc, e_rob};
    n_vec++;
    if (bus.alu_en !== e_en) begin
      n_err++; $display("FAIL %s alu_en: got %0b expected %0b", nm, bus.alu_en, e_en);
    end
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s payload: got %h expected %h", nm, got, exp);
    end
    n_vec++;
    if (bus.rs_full !== (cnt == N)) begin
      n_err++; $display("FAIL %s rs_full: got %0b expected %0b", nm, bus.rs_full, (cnt == N));
    end
  endtask

  task automatic expect_eq(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(string nm);
    model_step();
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0;
    bus.disp_valid = 1'b0; bus.alu_result = 1'b0; bus.lsb_result = 1'b0;
  endtask

  task automatic disp(logic [3:0] rob, logic r1, logic [31:0] v1, logic [3:0] t1,
                      logic r2, logic [31:0] v2, logic [3:0] t2);
    bus.disp_valid = 1'b1; bus.disp_opcode = OP_ARITH; bus.disp_funct3 = 3'd0;
    bus.disp_funct7 = 1'b0; bus.disp_imm = 32'h0; bus.disp_pc = {24'h0, rob, 4'h0};
    bus.disp_rob_pos = rob;
    bus.disp_rs1_ready = r1; bus.disp_rs1_val = v1; bus.disp_rs1_tag = t1;
    bus.disp_rs2_ready = r2; bus.disp_rs2_val = v2; bus.disp_rs2_tag = t2;
  endtask

  task automatic bcast_alu(logic [3:0] p, logic [31:0] v);
    bus.alu_result = 1'b1; bus.alu_result_rob_pos = p; bus.alu_result_val = v;
  endtask

  task automatic bcast_lsb(logic [3:0] p, logic [31:0] v);
    bus.lsb_result = 1'b1; bus.lsb_result_rob_pos = p; bus.lsb_result_val = v;
  endtask

  localparam int NV = 8;
  vec_t       vt [NV];
  logic [6:0] ops [7];

  initial begin
    int  next_k;
    bit  seen;
    ops = '{OP_ARITH, OP_ARITHI, OP_JAL, OP_JALR, OP_BRANCH, OP_LUI, OP_AUIPC};
    //         op        f3    f7    r1    v1            t1    r2    v2            t2    rob   imm           pc            ab    ap    av            lb    lp    lv            e1            e2
    vt[0] = '{OP_ARITH,  3'd0, 1'b0, 1'b1, 32'd5,        4'd0, 1'b1, 32'd7,        4'd0, 4'd3, 32'd0,        32'h100,      1'b0, 4'd0, 32'd0,        1'b0, 4'd0, 32'd0,        32'd5,        32'd7};
    vt[1] = '{OP_ARITH,  3'd0, 1'b0, 1'b1, 32'h10,       4'd0, 1'b0, 32'd0,        4'd2, 4'd4, 32'd0,        32'h104,      1'b1, 4'd2, 32'hFFFFFFFF, 1'b0, 4'd0, 32'd0,        32'h10,       32'hFFFFFFFF};
    vt[2] = '{OP_ARITHI, 3'd1, 1'b0, 1'b0, 32'd0,        4'd7, 1'b1, 32'h22,       4'd0, 4'd5, 32'h3,        32'h108,      1'b0, 4'd0, 32'd0,        1'b1, 4'd7, 32'hCAFE0001, 32'hCAFE0001, 32'h22};
    vt[3] = '{OP_ARITH,  3'd2, 1'b0, 1'b0, 32'd0,        4'd5, 1'b1, 32'd3,        4'd0, 4'd6, 32'd0,        32'h10C,      1'b1, 4'd5, 32'hA,        1'b1, 4'd5, 32'hB,        32'hA,        32'd3};
    vt[4] = '{OP_BRANCH, 3'd0, 1'b0, 1'b0, 32'd0,        4'd1, 1'b0, 32'd0,        4'd8, 4'd7, 32'hFFFFFFF0, 32'h110,      1'b1, 4'd1, 32'h111,      1'b1, 4'd8, 32'h888,      32'h111,      32'h888};
    vt[5] = '{OP_ARITH,  3'd4, 1'b0, 1'b1, 32'h55,       4'd2, 1'b1, 32'h66,       4'd2, 4'd8, 32'd0,        32'h114,      1'b1, 4'd2, 32'h99,       1'b0, 4'd0, 32'd0,        32'h55,       32'h66};
    vt[6] = '{OP_JAL,    3'd0, 1'b0, 1'b1, 32'd0,        4'd0, 1'b1, 32'd0,        4'd0, 4'd9, 32'h800,      32'h118,      1'b0, 4'd0, 32'd0,        1'b0, 4'd0, 32'd0,        32'd0,        32'd0};
    vt[7] = '{OP_ARITH,  3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 4'd0, 1'b1, 32'd1,        4'd0, 4'd15, 32'd0,       32'h11C,      1'b0, 4'd0, 32'd0,        1'b0, 4'd0, 32'd0,        32'hFFFFFFFF, 32'd1};

    bus.alu_result_rob_pos = '0; bus.alu_result_val = '0;
    bus.lsb_result_rob_pos = '0; bus.lsb_result_val = '0;
    disp(4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    idle();
    for (int i = 0; i < N; i++) m[i] = '{default: '0};

    // Reset
    rst = 1'b1;
    step("reset0");
    step("reset1");
    expect_eq("reset_alu_en", 32'(bus.alu_en), 32'd0);
    expect_eq("reset_rs_full", 32'(bus.rs_full), 32'd0);
    expect_eq("reset_alu_val1", bus.alu_val1, 32'd0);
    expect_eq("reset_alu_rob_pos", 32'(bus.alu_rob_pos), 32'd0);
    rst = 1'b0;
    step("post_reset");

    // Table: dispatch (with optional same-cycle broadcasts), issue one cycle later
    for (int k = 0; k < NV; k++) begin
      idle();
      bus.disp_valid = 1'b1; bus.disp_opcode = vt[k].op; bus.disp_funct3 = vt[k].f3;
      bus.disp_funct7 = vt[k].f7; bus.disp_imm = vt[k].imm; bus.disp_pc = vt[k].pc;
      bus.disp_rob_pos = vt[k].rob;
      bus.disp_rs1_ready = vt[k].r1; bus.disp_rs1_val = vt[k].v1; bus.disp_rs1_tag = vt[k].t1;
      bus.disp_rs2_ready = vt[k].r2; bus.disp_rs2_val = vt[k].v2; bus.disp_rs2_tag = vt[k].t2;
      if (vt[k].ab) bcast_alu(vt[k].ap, vt[k].av);
      if (vt[k].lb) bcast_lsb(vt[k].lp, vt[k].lv);
      step("tbl_disp");
      idle();
      step("tbl_issue");
      expect_eq("tbl_alu_en", 32'(bus.alu_en), 32'd1);
      expect_eq("tbl_alu_val1", bus.alu_val1, vt[k].e1);
      expect_eq("tbl_alu_val2", bus.alu_val2, vt[k].e2);
      expect_eq("tbl_alu_rob_pos", 32'(bus.alu_rob_pos), 32'(vt[k].rob));
      step("tbl_idle");
      expect_eq("tbl_alu_en_pulse", 32'(bus.alu_en), 32'd0);
    end

    // Wakeup from the LSB bus
    idle();
    disp(4'd1, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0);
    step("lsb_disp");
    idle();
    step("lsb_wait0");
    expect_eq("lsb_wait0_en", 32'(bus.alu_en), 32'd0);
    step("lsb_wait1");
    expect_eq("lsb_wait1_en", 32'(bus.alu_en), 32'd0);
    bcast_lsb(4'd6, 32'h1234);
    step("lsb_bcast");
`ifdef RS_CDB_BYPASS_EN
    expect_eq("lsb_bypass_en", 32'(bus.alu_en), 32'd1);
    expect_eq("lsb_bypass_val1", bus.alu_val1, 32'h1234);
    idle();
    step("lsb_after");
`else
    expect_eq("lsb_bcast_en", 32'(bus.alu_en), 32'd0);
    idle();
    step("lsb_issue");
    expect_eq("lsb_issue_en", 32'(bus.alu_en), 32'd1);
    expect_eq("lsb_issue_val1", bus.alu_val1, 32'h1234);
`endif
    step("lsb_idle");

    // Fill all entries waiting on tag 9, try one more, then release in index order
    for (int i = 0; i < N; i++) begin
      idle();
      disp(4'(i), 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0);
      step("fill");
    end
    expect_eq("full_set", 32'(bus.rs_full), 32'd1);
    idle();
    disp(4'd15, 1'b1, 32'hDEAD, 4'd0, 1'b1, 32'hBEEF, 4'd0);
    step("full_drop");
    expect_eq("full_drop_en", 32'(bus.alu_en), 32'd0);
    idle();
    bcast_alu(4'd9, 32'h99);
    next_k = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step("drain");
      idle();
      if (bus.alu_en) begin
        expect_eq("drain_order", 32'(bus.alu_rob_pos), 32'(next_k));
        expect_eq("drain_val1", bus.alu_val1, 32'h99);
        expect_eq("drain_val2", bus.alu_val2, 32'(next_k));
        if (!seen) expect_eq("full_drop_after_issue", 32'(bus.rs_full), 32'd0);
        seen = 1'b1;
        next_k++;
      end
    end
    expect_eq("drain_count", 32'(next_k), 32'd16);

    // Rollback with five waiting entries and one about to issue
    for (int i = 0; i < 5; i++) begin
      idle();
      disp(4'(i), 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0);
      step("rb_fill");
    end
    idle();
    disp(4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    step("rb_pending");
    idle();
    rollback = 1'b1;
    disp(4'd6, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0);
    step("rollback");
    expect_eq("rollback_en", 32'(bus.alu_en), 32'd0);
    expect_eq("rollback_full", 32'(bus.rs_full), 32'd0);
    idle();
    bcast_alu(4'd12, 32'h77);
    for (int c = 0; c < 3; c++) begin
      step("rb_quiet");
      idle();
      expect_eq("rb_quiet_en", 32'(bus.alu_en), 32'd0);
    end
    disp(4'd7, 1'b1, 32'h70, 4'd0, 1'b1, 32'h71, 4'd0);
    step("rb_new_disp");
    idle();
    step("rb_new_issue");
    expect_eq("rb_new_issue_en", 32'(bus.alu_en), 32'd1);
    expect_eq("rb_new_issue_rob", 32'(bus.alu_rob_pos), 32'd7);
    step("rb_idle");

    // rdy freeze while alu_en is high and during a dispatch plus broadcast
    disp(4'd2, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0);
    step("frz_disp");
    idle();
    step("frz_issue");
    rdy = 1'b0;
    step("frz_hold0");
    expect_eq("frz_hold_en", 32'(bus.alu_en), 32'd1);
    disp(4'd9, 1'b1, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0);
    bcast_alu(4'd3, 32'h1);
    rdy = 1'b0;
    step("frz_hold1");
    expect_eq("frz_hold1_en", 32'(bus.alu_en), 32'd1);
    expect_eq("frz_hold1_rob", 32'(bus.alu_rob_pos), 32'd2);
    idle();
    step("frz_resume0");
    expect_eq("frz_resume_en", 32'(bus.alu_en), 32'd0);
    step("frz_resume1");
    expect_eq("frz_no_ghost", 32'(bus.alu_en), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 79) == 0);
      bus.disp_valid     = ($urandom_range(0, 2) != 0);
      bus.disp_opcode    = ops[$urandom_range(0, 6)];
      bus.disp_funct3    = 3'($urandom);
      bus.disp_funct7    = 1'($urandom);
      bus.disp_imm       = $urandom;
      bus.disp_pc        = $urandom;
      bus.disp_rob_pos   = 4'($urandom);
      bus.disp_rs1_ready = ($urandom_range(0, 1) != 0);
      bus.disp_rs1_val   = $urandom;
      bus.disp_rs1_tag   = 4'($urandom_range(0, 7));
      bus.disp_rs2_ready = ($urandom_range(0, 1) != 0);
      bus.disp_rs2_val   = $urandom;
      bus.disp_rs2_tag   = 4'($urandom_range(0, 7));
      bus.alu_result         = ($urandom_range(0, 2) == 0);
      bus.alu_result_rob_pos = 4'($urandom_range(0, 7));
      bus.alu_result_val     = $urandom;
      bus.lsb_result         = ($urandom_range(0, 2) == 0);
      bus.lsb_result_rob_pos = 4'($urandom_range(0, 7));
      bus.lsb_result_val     = $urandom;
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation station feeding the integer ALU in the out-of-order core. It buffers dispatched ALU, branch, and jump instructions and waits for source operands. Waiting operands are captured from the ALU and LSB result broadcasts. Each cycle it issues at most one fully-ready entry to the ALU's `alu_en` port group. A ROB rollback flushes every entry.

## Interface
- `RS_SIZE`, default 16: number of entries (power of two, ≥2).
- `ROB_POS_W`, default 4: ROB index width; must match `ROB_POS_WID`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready. While low, all state holds.
- `rollback` in 1: flush all entries.
- `disp_valid` in 1: dispatch an instruction this cycle.
- `disp_opcode` in 7, `disp_funct3` in 3, `disp_funct7` in 1: decoded fields.
- `disp_imm` in 32, `disp_pc` in 32, `disp_rob_pos` in ROB_POS_W: immediate, PC, and destination ROB slot.
- `disp_rs1_ready` in 1, `disp_rs1_val` in 32, `disp_rs1_tag` in ROB_POS_W: operand 1. The value is valid when ready; otherwise the tag names the producing ROB slot.
- `disp_rs2_ready` in 1, `disp_rs2_val` in 32, `disp_rs2_tag` in ROB_POS_W: operand 2. Dispatch sets ready=1 for instructions that use no rs2.
- `rs_full` out 1: no free entry.
- `alu_result` in 1, `alu_result_rob_pos` in ROB_POS_W, `alu_result_val` in 32: ALU broadcast.
- `lsb_result` in 1, `lsb_result_rob_pos` in ROB_POS_W, `lsb_result_val` in 32: load/store buffer broadcast.
- `alu_en` out 1, `alu_opcode` out 7, `alu_funct3` out 3, `alu_funct7` out 1: issue to the ALU.
- `alu_val1` out 32, `alu_val2` out 32, `alu_imm` out 32, `alu_pc` out 32, `alu_rob_pos` out ROB_POS_W: issue payload.

## Operation
- **Entry contents:** busy, opcode, funct3, funct7, imm, pc, rob_pos, and per operand a (ready, val, tag) triple.
- **Dispatch:**
  - When `disp_valid` is high, the entry is written into the lowest-index free slot.
  - The dispatcher must not assert `disp_valid` while `rs_full` is high. If it does anyway, the request is dropped.
- **Dispatch-time capture:**
  - A not-ready dispatched operand whose tag matches a valid broadcast in the same cycle is stored as ready, with the broadcast value.
  - ALU has priority over LSB if both match.
- **Wakeup:**
  - At every active edge, each busy entry's not-ready operand whose tag equals `alu_result_rob_pos` (with `alu_result`=1) or `lsb_result_rob_pos` (with `lsb_result`=1) captures that value and becomes ready.
  - Both operands may wake in the same cycle, from the same or different buses.
- **Issue:**
  - The lowest-index busy entry with both operands ready is selected, based on stored ready bits.
  - At the edge, the payload is registered to the `alu_*` outputs, `alu_en` is set to 1, and the entry's busy bit is cleared.
  - If no entry is ready, `alu_en` is 0 and the payload outputs hold their previous values.
- **Simultaneous events:** dispatch, one issue, and wakeups may all happen in one cycle. A slot freed by issue is not available to a dispatch in the same cycle.
- **`rs_full`:** combinational, high when all `RS_SIZE` busy bits are set.
- **Rollback** (takes priority over all but `rst`): clears all busy bits and sets `alu_en`=0 at that edge. Dispatch in that cycle is ignored.
- **Reset:** all busy bits 0, `alu_en` 0, every `alu_*` output 0, `rs_full` 0.

## Timing
- Dispatch with both operands ready, RS empty:
  - captured at edge N;
  - `alu_en`=1 after edge N+1;
  - ALU result broadcast after edge N+2.
- Waiting operand, broadcast present during the cycle ending at edge M: the entry becomes ready at M and issues at M+1 (without the bypass in Configuration).
- `alu_en` is a one-cycle pulse per issued instruction. Back-to-back issue is allowed every cycle.
- When `rdy`=0, nothing changes, including `alu_en`. The ALU is also frozen by `rdy`.
- Issue throughput is one per cycle; dispatch throughput is one per cycle.

## Configuration
- **`RS_CDB_BYPASS_EN` defined:** selection also considers entries whose last missing operand(s) match a valid broadcast this cycle. Such an entry issues at edge M with the broadcast value substituted into `alu_val1`/`alu_val2`, saving one cycle. Lowest-index priority is unchanged.
- **Undefined:** selection uses stored ready bits only, as described in Operation.

## Structure
- Shared defines go in `Mydefine.v`:
  - widths `OP_WID`, `FUNCT3_WID`, `ROB_POS_WID`;
  - opcode constants for ARITH, ARITHI, JAL, JALR, BRANCH, LUI, AUIPC;
  - `RS_SIZE` default.
- Sub-module `rs_pick`: a parameterised lowest-index priority encoder over a bit vector, returning a found flag and an index.
  - Instantiated twice: once for the free slot, once for the ready slot.

## Test plan
- **Ready dispatch:** reset, then dispatch ADD with rs1=5, rs2=7, rob_pos=3, both ready. Expect `alu_en`=1 exactly one cycle later with `alu_val1`=5, `alu_val2`=7, `alu_rob_pos`=3, then `alu_en`=0.
- **Wakeup from LSB:** dispatch with rs1 waiting on tag 6. Hold 2 cycles, expect no issue. Pulse `lsb_result` with rob_pos=6, val=0x1234. Expect issue on the next cycle with `alu_val1`=0x1234; with `RS_CDB_BYPASS_EN`, issue on the same edge.
- **Full and priority:** fill 16 entries, all waiting on tag 9. Expect `rs_full`=1. Broadcast tag 9 on the ALU bus, then expect issue order entries 0,1,2,… one per cycle, with `rs_full` dropping after the first issue.
- **Same-cycle capture:** dispatch rs2 waiting on tag 2 while `alu_result` broadcasts rob_pos=2, val=0xFFFF_FFFF. Expect the entry to issue next cycle with `alu_val2`=0xFFFF_FFFF.
- **Rollback:** with 5 busy entries and one issue pending, assert `rollback`. Expect `alu_en`=0, `rs_full`=0, and no issue in following cycles until a new dispatch.
- **`rdy` freeze:** with `rdy`=0 during a dispatch and broadcast, expect no state change. After `rdy` returns to 1, behaviour matches a run with no stall cycles.
